tex_spi_arbiter: RTL and testbench

Shares the single external texture QSPI flash (tex_csb / tex_sclk / bidirectional tex_io0 / tex_in[3:0]) between two read requesters: requester 0 is the raybox-zero row/texture fetcher, requester 1 is a debug/SoC reader. It arbitrates round-robin, runs one Quad Output Fast Read (0x6B) transaction per grant, and returns the read bytes to the winner with a one-cycle ack. It sits between the renderer core and the tex_* pads in top_raybox_zero_fsm.

---
 rtl/tex_spi_pkg.sv | 16 +
 rtl/tex_spi_rr_arb.sv | 22 ++
 rtl/tex_spi_arbiter.sv | 147 ++++++++++++++
 tb/tb_tex_spi_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tex_spi_pkg.sv
// tex_spi_pkg: shared types and constants for the texture QSPI arbiter.
// Provides the FSM state enum, the default Quad Output Fast Read opcode,
// the flash address width and the width of the shared bit counter.
package tex_spi_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_DONE
   } state_t;
   localparam logic [7:0] SPI_CMD_QOFR = 8'h6B;
   localparam int ADDR_BITS = 24;
   localparam int CNT_W = 6;
endpackage

// File: rtl/tex_spi_rr_arb.sv
// tex_spi_rr_arb: two-way round-robin arbiter producing a one-hot grant.
// Ports: i_clk/i_reset (async, active high), i_req request levels,
// i_adv strobe at end of a transaction, i_last1 = requester 1 was served,
// o_gnt one-hot grant (combinational from i_req and the priority pointer).
module tex_spi_rr_arb (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_req,
   input  logic       i_adv,
   input  logic       i_last1,
   output logic [1:0] o_gnt
);
   logic pri_q, pri_d;
   // pri_q = 1 means requester 1 wins a tie; after serving one side the other is preferred
   always_comb begin
      pri_d = i_adv ? ~i_last1 : pri_q;
      o_gnt = (&i_req) ? (pri_q ? 2'b10 : 2'b01) : i_req;
   end
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) pri_q <= 1'b0;
      else pri_q <= pri_d;
endmodule

// File: rtl/tex_spi_arbiter.sv
// tex_spi_arbiter: shares one texture QSPI flash between two read requesters.
// Ports: i_clk/i_reset (async, active high); i_req[1:0] request levels with
// i_addr0/i_addr1 byte addresses; o_ack one-cycle pulse with o_data (first
// byte in MSBs); o_busy; flash pads o_tex_csb, o_tex_sclk, o_tex_oeb0,
// o_tex_out0 (all registered) and i_tex_in[3:0] (bit 0 = io0).
module tex_spi_arbiter
   import tex_spi_pkg::*;
#(
   parameter int         NBYTES = 3,
   parameter logic [7:0] CMD    = SPI_CMD_QOFR,
   parameter int         DUMMY  = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [1:0]             i_req,
   input  logic [ADDR_BITS-1:0]   i_addr0,
   input  logic [ADDR_BITS-1:0]   i_addr1,
   output logic [1:0]             o_ack,
   output logic [8*NBYTES-1:0]    o_data,
   output logic                   o_busy,
   output logic                   o_tex_csb,
   output logic                   o_tex_sclk,
   output logic                   o_tex_oeb0,
   output logic                   o_tex_out0,
   input  logic [3:0]             i_tex_in
);
   localparam int DW = 8 * NBYTES;
   state_t             state_q, state_d;
   logic               phase_q, phase_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        sh_q, sh_d;
   logic [DW-1:0]      din_q, din_d, data_q, data_d;
   logic [1:0]         gnt_q, gnt_d, ack_q, ack_d, gnt;
   logic               adv, shifting, active;
   logic               csb_q, csb_d, sclk_q, sclk_d, oeb_q, oeb_d, out0_q, out0_d, busy_q, busy_d;
   tex_spi_rr_arb u_arb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_req   (i_req),
      .i_adv   (adv),
      .i_last1 (gnt_q[1]),
      .o_gnt   (gnt)
   );
   // phase_q: 0 = SCLK low half, 1 = SCLK high half; the counter holds the
   // remaining SPI clocks of the current state minus one and steps at the end of phase B
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      din_d   = din_q;
      gnt_d   = gnt_q;
      ack_d   = 2'b00;
      data_d  = data_q;
      adv     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|i_req) begin
               state_d = ST_CMD;
               phase_d = 1'b0;
               cnt_d   = CNT_W'(7);
               gnt_d   = gnt;
               sh_d    = {CMD, gnt[1] ? i_addr1 : i_addr0};
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            adv     = 1'b1;
         end
         default: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               sh_d  = sh_q << 1;
               din_d = (state_q == ST_DATA) ? {din_q[DW-5:0], i_tex_in} : din_q;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  case (state_q)
                     ST_CMD: begin
                        state_d = ST_ADDR;
                        cnt_d   = CNT_W'(ADDR_BITS - 1);
                     end
                     ST_ADDR: begin
                        state_d = ST_DUMMY;
                        cnt_d   = CNT_W'(DUMMY - 1);
                     end
                     ST_DUMMY: begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_W'(2 * NBYTES - 1);
                     end
                     ST_DATA: begin
                        state_d = ST_DONE;
                        ack_d   = gnt_q;
                        data_d  = din_d;
                     end
                     default: state_d = ST_IDLE;
                  endcase
               end
            end
         end
      endcase
      // pad values are computed from the next state so the pins come straight from flops
      shifting = (state_d == ST_CMD) || (state_d == ST_ADDR);
      active   = state_d inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
      csb_d    = ~active;
      sclk_d   = active & phase_d;
      oeb_d    = ~shifting;
      out0_d   = shifting & sh_d[31];
      busy_d   = state_d != ST_IDLE;
   end
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         state_q <= ST_IDLE;
         phase_q <= 1'b0;
         cnt_q   <= '0;
         sh_q    <= '0;
         din_q   <= '0;
         data_q  <= '0;
         gnt_q   <= 2'b00;
         ack_q   <= 2'b00;
         csb_q   <= 1'b1;
         sclk_q  <= 1'b0;
         oeb_q   <= 1'b1;
         out0_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         din_q   <= din_d;
         data_q  <= data_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         csb_q   <= csb_d;
         sclk_q  <= sclk_d;
         oeb_q   <= oeb_d;
         out0_q  <= out0_d;
         busy_q  <= busy_d;
      end
   assign o_ack      = ack_q;
   assign o_data     = data_q;
   assign o_busy     = busy_q;
   assign o_tex_csb  = csb_q;
   assign o_tex_sclk = sclk_q;
   assign o_tex_oeb0 = oeb_q;
   assign o_tex_out0 = out0_q;
endmodule

// File: tb/tb_tex_spi_arbiter.sv
// tb_tex_spi_arbiter: directed bench for the texture QSPI arbiter with a shared flash model.
module tb_tex_spi_arbiter;
   localparam int FL_DUMMY = 8;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_a, req_b, ack_a, ack_b;
   logic [23:0] addr0_a, addr1_a, addr0_b, addr1_b, data_a;
   logic [7:0]  data_b;
   logic        busy_a, csb_a, sclk_a, oeb_a, out0_a;
   logic        busy_b, csb_b, sclk_b, oeb_b, out0_b;
   logic [3:0]  tex_in;
   int          vecs = 0;
   int          errs = 0;
   int          n;
   always #5 clk = ~clk;

   tex_spi_arbiter #(.NBYTES(3)) dut_a (
      .i_clk(clk), .i_reset(rst), .i_req(req_a), .i_addr0(addr0_a), .i_addr1(addr1_a),
      .o_ack(ack_a), .o_data(data_a), .o_busy(busy_a), .o_tex_csb(csb_a), .o_tex_sclk(sclk_a),
      .o_tex_oeb0(oeb_a), .o_tex_out0(out0_a), .i_tex_in(tex_in)
   );
   tex_spi_arbiter #(.NBYTES(1)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_req(req_b), .i_addr0(addr0_b), .i_addr1(addr1_b),
      .o_ack(ack_b), .o_data(data_b), .o_busy(busy_b), .o_tex_csb(csb_b), .o_tex_sclk(sclk_b),
      .o_tex_oeb0(oeb_b), .o_tex_out0(out0_b), .i_tex_in(tex_in)
   );

   // flash contents: a few fixed bytes, otherwise a simple address hash
   function automatic logic [7:0] fbyte(input logic [23:0] a);
      case (a)
         24'h012345: return 8'hA1;
         24'h012346: return 8'hB2;
         24'h012347: return 8'hC3;
         24'hFFFFFF: return 8'h5A;
         default:    return a[7:0] ^ a[15:8] ^ 8'h3C;
      endcase
   endfunction
   function automatic logic [3:0] nib(input logic [23:0] a, input int k);
      logic [7:0] b;
      b = fbyte(a + 24'(k / 2));
      return k[0] ? b[3:0] : b[7:4];
   endfunction
   function automatic logic [23:0] exp3(input logic [23:0] a);
      return {fbyte(a), fbyte(a + 24'd1), fbyte(a + 24'd2)};
   endfunction

   // one flash shared by both DUTs; only one is ever active at a time
   logic        f_csb, f_sclk, f_out0, f_oeb;
   int          fbits, ferr;
   logic [31:0] rx;
   assign f_csb  = csb_a & csb_b;
   assign f_sclk = sclk_a | sclk_b;
   assign f_out0 = out0_a | out0_b;
   assign f_oeb  = csb_a ? oeb_b : oeb_a;
   always @(posedge f_sclk or posedge f_csb) begin
      if (f_csb) fbits <= 0;
      else begin
         if (fbits < 32) begin
            rx <= {rx[30:0], f_out0};
            if (f_oeb !== 1'b0) ferr <= ferr + 1;
         end else if (f_oeb !== 1'b1 || f_out0 !== 1'b0) ferr <= ferr + 1;
         if (fbits >= 32 + FL_DUMMY) tex_in <= nib(rx[23:0], fbits - 32 - FL_DUMMY);
         fbits <= fbits + 1;
      end
   end

   task automatic start_a(input logic [1:0] r);
      @(negedge clk);
      req_a = r;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input bit use_b, output int cnt);
      cnt = 0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         #1;
         if ((use_b ? ack_b : ack_a) != 2'b00) begin
            cnt = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_a = 2'b11;
      req_b = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      vecs++;
      if ({csb_a, sclk_a, oeb_a, out0_a, busy_a, ack_a} !== 7'b1010000) begin
         errs++;
         $display("FAIL reset_pins_a: got %b expected 1010000", {csb_a, sclk_a, oeb_a, out0_a, busy_a, ack_a});
      end
      vecs++;
      if (data_a !== 24'h0) begin
         errs++;
         $display("FAIL reset_data_a: got %h expected 000000", data_a);
      end
      vecs++;
      if ({csb_b, sclk_b, oeb_b, out0_b, busy_b, ack_b, data_b} !== {7'b1010000, 8'h00}) begin
         errs++;
         $display("FAIL reset_b: got %b expected 101000000000000", {csb_b, sclk_b, oeb_b, out0_b, busy_b, ack_b, data_b});
      end
      @(negedge clk);
      req_a = 2'b00;
      req_b = 2'b00;
      rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_single;
      addr0_a = 24'h012345;
      start_a(2'b01);
      vecs++;
      if ({csb_a, busy_a} !== 2'b01) begin
         errs++;
         $display("FAIL single_start: got csb/busy %b expected 01", {csb_a, busy_a});
      end
      wait_ack(1'b0, n);
      vecs++;
      if (n != 92) begin
         errs++;
         $display("FAIL single_latency: got %0d expected 92", n);
      end
      vecs++;
      if (ack_a !== 2'b01 || data_a !== 24'hA1B2C3) begin
         errs++;
         $display("FAIL single_ack: got ack %b data %h expected 01 A1B2C3", ack_a, data_a);
      end
      vecs++;
      if (rx !== 32'h6B012345 || ferr != 0) begin
         errs++;
         $display("FAIL single_bitstream: got %h err %0d expected 6b012345 err 0", rx, ferr);
      end
      vecs++;
      if ({csb_a, busy_a} !== 2'b11) begin
         errs++;
         $display("FAIL single_done: got csb/busy %b expected 11", {csb_a, busy_a});
      end
      @(negedge clk);
      req_a = 2'b00;
      @(posedge clk);
      #1;
      vecs++;
      if ({ack_a, busy_a} !== 3'b000) begin
         errs++;
         $display("FAIL single_idle: got ack/busy %b expected 000", {ack_a, busy_a});
      end
   endtask

   task automatic test_contention;
      logic [1:0] exp_ack;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      addr0_a = 24'h100000;
      addr1_a = 24'h200010;
      start_a(2'b11);
      for (int t = 0; t < 4; t++) begin
         exp_ack = t[0] ? 2'b10 : 2'b01;
         wait_ack(1'b0, n);
         vecs++;
         if (n != ((t == 0) ? 92 : 94) || ack_a !== exp_ack) begin
            errs++;
            $display("FAIL contention_ack%0d: got ack %b after %0d expected %b after %0d", t, ack_a, n, exp_ack, (t == 0) ? 92 : 94);
         end
         vecs++;
         if (data_a !== exp3(t[0] ? addr1_a : addr0_a)) begin
            errs++;
            $display("FAIL contention_data%0d: got %h expected %h", t, data_a, exp3(t[0] ? addr1_a : addr0_a));
         end
      end
      @(negedge clk);
      req_a = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      vecs++;
      if (busy_a !== 1'b0) begin
         errs++;
         $display("FAIL contention_release: got busy %b expected 0", busy_a);
      end
   endtask

   task automatic test_back_to_back;
      int gap;
      addr1_a = 24'hABCDE0;
      start_a(2'b10);
      wait_ack(1'b0, n);
      vecs++;
      if (n != 92 || ack_a !== 2'b10 || csb_a !== 1'b1) begin
         errs++;
         $display("FAIL b2b_first: got ack %b after %0d csb %b expected 10 after 92 csb 1", ack_a, n, csb_a);
      end
      gap = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (csb_a === 1'b0) begin
            gap = i;
            break;
         end
      end
      vecs++;
      if (gap != 2) begin
         errs++;
         $display("FAIL b2b_gap: got %0d expected 2", gap);
      end
      wait_ack(1'b0, n);
      vecs++;
      if (n != 92 || data_a !== exp3(24'hABCDE0)) begin
         errs++;
         $display("FAIL b2b_second: got data %h after %0d expected %h after 92", data_a, n, exp3(24'hABCDE0));
      end
      @(negedge clk);
      req_a = 2'b00;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_mid;
      int acks;
      addr0_a = 24'h012345;
      start_a(2'b01);
      repeat (40) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      vecs++;
      if ({csb_a, oeb_a, busy_a, ack_a} !== 5'b11000) begin
         errs++;
         $display("FAIL midreset_pins: got %b expected 11000", {csb_a, oeb_a, busy_a, ack_a});
      end
      req_a = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      acks = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (ack_a != 2'b00) acks++;
      end
      vecs++;
      if (acks != 0) begin
         errs++;
         $display("FAIL midreset_noack: got %0d acks expected 0", acks);
      end
      ferr = 0;
      start_a(2'b01);
      wait_ack(1'b0, n);
      vecs++;
      if (n != 92 || data_a !== 24'hA1B2C3 || rx !== 32'h6B012345 || ferr != 0) begin
         errs++;
         $display("FAIL midreset_restart: got %0d data %h rx %h err %0d expected 92 a1b2c3 6b012345 0", n, data_a, rx, ferr);
      end
      @(negedge clk);
      req_a = 2'b00;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_nbytes1;
      addr1_b = 24'hFFFFFF;
      @(negedge clk);
      req_b = 2'b10;
      @(posedge clk);
      #1;
      wait_ack(1'b1, n);
      vecs++;
      if (n != 84 || ack_b !== 2'b10) begin
         errs++;
         $display("FAIL nb1_ack: got ack %b after %0d expected 10 after 84", ack_b, n);
      end
      vecs++;
      if (data_b !== 8'h5A || rx !== 32'h6BFFFFFF || ferr != 0) begin
         errs++;
         $display("FAIL nb1_data: got %h rx %h err %0d expected 5a 6bffffff 0", data_b, rx, ferr);
      end
      @(negedge clk);
      req_b = 2'b00;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      rst = 1'b1;
      req_a = 2'b00;
      req_b = 2'b00;
      addr0_a = '0;
      addr1_a = '0;
      addr0_b = '0;
      addr1_b = '0;
      tex_in = 4'h0;
      rx = '0;
      ferr = 0;
      test_reset;
      test_single;
      test_contention;
      test_back_to_back;
      test_reset_mid;
      test_nbytes1;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
